// File: rtl/compare_pkg.sv
// Shared constants for compare_seq: FSM state encodings and one-hot result codes.
package compare_pkg;

    localparam logic [1:0] CMP_IDLE = 2'd0;
    localparam logic [1:0] CMP_CMP  = 2'd1;
    localparam logic [1:0] CMP_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = CMP_IDLE,
        ST_CMP  = CMP_CMP,
        ST_DONE = CMP_DONE
    } cmp_state_t;

    // Result bits ordered {PBIG, SAME, QBIG}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_PBIG = 3'b100;
    localparam logic [2:0] RES_SAME = 3'b010;
    localparam logic [2:0] RES_QBIG = 3'b001;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational compare of one CHUNK-bit slice; flip_msb turns the slice
// into a two's-complement ordering by inverting the MSB of both operands.
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             flip_msb,
    output logic             gt,
    output logic             eq
);

    logic [CHUNK-1:0] msb_mask;

    always_comb begin
        msb_mask = '0;
        msb_mask[CHUNK-1] = flip_msb;
    end

    assign gt = (a ^ msb_mask) > (b ^ msb_mask);
    assign eq = (a == b);

endmodule

// File: rtl/compare_seq.sv
// Multi-cycle magnitude comparator, MSB chunk first with early exit and
// valid/ready on both sides. Define CMP_SIGNED_EN to add the signed_mode port.
module compare_seq
    import compare_pkg::*;
#(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] P,
    input  logic [W-1:0] Q,
`ifdef CMP_SIGNED_EN
    input  logic         signed_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic         PBIG,
    output logic         SAME,
    output logic         QBIG
);

    localparam int NCHUNK = W / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_cfg
            $error("compare_seq: W must be a positive multiple of CHUNK");
        end
    endgenerate

    cmp_state_t      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    p_q, p_d;
    logic [W-1:0]    q_q, q_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [2:0]      res_q, res_d;
    logic            flip_msb;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic            chunk_gt, chunk_eq;

`ifdef CMP_SIGNED_EN
    logic signed_q, signed_d;
    // Only the top chunk carries the sign bit
    assign flip_msb = signed_q && (idx_q == IDX_TOP);
`else
    assign flip_msb = 1'b0;
`endif

    assign a_chunk = p_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk = q_q[idx_q*CHUNK +: CHUNK];

    cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_chunk),
        .b        (b_chunk),
        .flip_msb (flip_msb),
        .gt       (chunk_gt),
        .eq       (chunk_eq)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        p_d         = p_q;
        q_d         = q_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
`ifdef CMP_SIGNED_EN
        signed_d    = signed_q;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    p_d        = P;
                    q_d        = Q;
`ifdef CMP_SIGNED_EN
                    signed_d   = signed_mode;
`endif
                    idx_d      = IDX_TOP;
                    res_d      = RES_NONE;
                    in_ready_d = 1'b0;
                    state_d    = ST_CMP;
                end
            end
            ST_CMP: begin
                if (!chunk_eq) begin
                    res_d       = chunk_gt ? RES_PBIG : RES_QBIG;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (idx_q == '0) begin
                    res_d       = RES_SAME;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                // Flags intentionally keep their value after the handshake
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= RES_NONE;
`ifdef CMP_SIGNED_EN
            signed_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            p_q         <= p_d;
            q_q         <= q_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
`ifdef CMP_SIGNED_EN
            signed_q    <= signed_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign PBIG      = res_q[2];
    assign SAME      = res_q[1];
    assign QBIG      = res_q[0];

endmodule

// File: tb/tb_compare_seq.sv
// Self-checking bench for compare_seq: directed table, back-pressure, mid-op reset,
// random pairs against an arithmetic model, and a W=16/CHUNK=16 back-to-back instance.
module tb_compare_seq;

`ifdef CMP_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0, sm = 1'b0;
    logic [31:0] p_in = '0, q_in = '0;
    logic        in_ready, out_valid, pbig, same, qbig;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1;
    logic [15:0] p16 = '0, q16 = '0;
    logic        in_ready16, out_valid16, pbig16, same16, qbig16;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    compare_seq #(.W(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .P(p_in), .Q(q_in),
`ifdef CMP_SIGNED_EN
        .signed_mode(sm),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .PBIG(pbig), .SAME(same), .QBIG(qbig)
    );

    compare_seq #(.W(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .P(p16), .Q(q16),
`ifdef CMP_SIGNED_EN
        .signed_mode(1'b0),
`endif
        .out_valid(out_valid16), .out_ready(out_ready16),
        .PBIG(pbig16), .SAME(same16), .QBIG(qbig16)
    );

    typedef struct {
        logic [31:0] p;
        logic [31:0] q;
        logic        sm;
        logic [2:0]  flags;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: ordering by plain arithmetic, latency from the highest differing bit
    function automatic void model32(input logic [31:0] p, input logic [31:0] q, input logic sm,
                                    output logic [2:0] fl, output int lat);
        logic [31:0] x;
        int top;
        bit gt;
        x = p ^ q;
        top = -1;
        for (int b = 0; b < 32; b++) if (x[b]) top = b;
        if (top < 0) begin
            fl  = 3'b010;
            lat = 4;
        end else begin
            lat = 4 - top / 8;
            if (sm && SIGNED_BUILD) gt = ($signed(p) > $signed(q));
            else                    gt = (p > q);
            fl = gt ? 3'b100 : 3'b001;
        end
    endfunction

    // Accepts one pair, measures cycles to out_valid, then completes the result handshake
    task automatic do_pair(input logic [31:0] p, input logic [31:0] q, input logic s,
                           output logic [2:0] fl, output int lat);
        int guard = 0;
        while (!in_ready && guard < 20) begin tick(); guard++; end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        p_in = p; q_in = q; sm = s; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        fl = {pbig, same, qbig};
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ov_after_hs", {31'd0, out_valid}, 32'd0);
        $display("pair P=%08h Q=%08h sm=%0b -> flags=%03b lat=%0d", p, q, s, fl, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] fl, efl, held;
        int lat, elat;
        logic [31:0] rp, rq, mask;
        int k;

        vecs[0] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b100, 1};
        vecs[1] = '{32'h12345678, 32'h12345678, 1'b0, 3'b010, 4};
        vecs[2] = '{32'h00000001, 32'h00000002, 1'b0, 3'b001, 4};
        vecs[3] = '{32'hAB000000, 32'hAB00FF00, 1'b0, 3'b001, 3};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 1};
        vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, SIGNED_BUILD ? 3'b001 : 3'b100, 1};
        vecs[6] = '{32'hFF000000, 32'hFF000001, 1'b1, 3'b001, 4};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 3'b010, 4};
        vecs[8] = '{32'h7F000000, 32'h80000000, 1'b1, SIGNED_BUILD ? 3'b100 : 3'b001, 1};

        // Reset state
        tick(); tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags", {29'd0, pbig, same, qbig}, 32'd0);
        rst = 1'b0;
        tick();
        check("in_ready_rise", {31'd0, in_ready}, 32'd1);
        check("in_ready16_rise", {31'd0, in_ready16}, 32'd1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_pair(vecs[i].p, vecs[i].q, vecs[i].sm, fl, lat);
            check($sformatf("vec%0d_flags", i), {29'd0, fl}, {29'd0, vecs[i].flags});
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Back-pressure: result held, no accept while a different pair is offered
        p_in = 32'h00000005; q_in = 32'h00000009; sm = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin tick(); k++; end
        check("bp_lat", k, 4);
        held = {pbig, same, qbig};
        check("bp_flags", {29'd0, held}, {29'd0, 3'b001});
        p_in = 32'hF0000000; q_in = 32'h00000001; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_ov_hold", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_flags_hold", {29'd0, pbig, same, qbig}, {29'd0, held});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_ov", {31'd0, out_valid}, 32'd0);
        check("bp_flags_kept", {29'd0, pbig, same, qbig}, {29'd0, held});
        // The offered pair is taken only now, on the edge after the handshake
        tick();
        in_valid = 1'b0;
        check("bp_late_accept", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_late_result", {28'd0, out_valid, pbig, same, qbig}, {28'd0, 4'b1100});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during CMP, second cycle
        p_in = 32'h12345678; q_in = 32'h12345678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_ov", {31'd0, out_valid}, 32'd0);
        check("midrst_flags", {29'd0, pbig, same, qbig}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) k++;
        end
        check("midrst_no_result", k, 0);
        do_pair(32'h00010000, 32'h00000FFF, 1'b0, fl, lat);
        check("postrst_flags", {29'd0, fl}, {29'd0, 3'b100});
        check("postrst_lat", lat, 2);

        // Random pairs, differences steered into chosen chunks
        for (int i = 0; i < 40; i++) begin
            rp = $urandom;
            k = $urandom_range(0, 4);
            mask = (k == 4) ? 32'd0 : (32'hFFFFFFFF >> (8 * k));
            rq = rp ^ ($urandom & mask);
            model32(rp, rq, i[0], efl, elat);
            do_pair(rp, rq, i[0], fl, lat);
            check("rand_flags", {29'd0, fl}, {29'd0, efl});
            check("rand_lat", lat, elat);
        end

        // Single-chunk instance: back-to-back accepts every third cycle
        for (int i = 0; i < 6; i++) begin
            p16 = 16'($urandom);
            q16 = (i == 0) ? p16 : 16'($urandom);
            if (i == 1) q16 = p16 + 16'd1;
            in_valid16 = 1'b1;
            check("b2b_ready_before", {31'd0, in_ready16}, 32'd1);
            tick();
            check("b2b_accepted", {31'd0, in_ready16}, 32'd0);
            tick();
            efl = (p16 > q16) ? 3'b100 : (p16 == q16) ? 3'b010 : 3'b001;
            check("b2b_ov", {31'd0, out_valid16}, 32'd1);
            check("b2b_flags", {29'd0, pbig16, same16, qbig16}, {29'd0, efl});
            $display("pair16 P=%04h Q=%04h -> flags=%03b", p16, q16, {pbig16, same16, qbig16});
            p16 = ~p16;
            tick();
            check("b2b_idle", {30'd0, out_valid16, in_ready16}, 32'd1);
        end
        in_valid16 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
